// File: rtl/clint_mtimer.sv
// rtl/clint_mtimer.sv - 64-bit machine timer with prescaler, compare and level interrupt
//
// Purpose: mtime counter advanced by a programmable prescaler, compared against
// mtimecmp to raise a level timer interrupt. 32-bit register slave.
//
// Ports:
//   clk        core clock
//   rst        synchronous reset, active low
//   req_i      one-cycle bus access strobe
//   we_i       1 = write, 0 = read (qualified by req_i)
//   addr_i     byte address, bits [4:2] select the register
//   data_i     write data (full word)
//   data_o     read data, combinational, 0 unless this is a read cycle
//   int_sig_o  timer interrupt request (PEND & IE)

module clint_mtimer #(
   parameter int PRESC_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        int_sig_o
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_PRESC  = 3'd1;
   localparam logic [2:0] OFF_MT_LO  = 3'd2;
   localparam logic [2:0] OFF_MT_HI  = 3'd3;
   localparam logic [2:0] OFF_CMP_LO = 3'd4;
   localparam logic [2:0] OFF_CMP_HI = 3'd5;

   logic               en_q, en_d;
   logic               ie_q, ie_d;
   logic               pend_q, pend_d;
   logic               auto_q, auto_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [63:0]        mtime_q, mtime_d;
   logic [63:0]        cmp_q, cmp_d;
   logic [31:0]        shadow_q, shadow_d;

   logic       wr, rd;
   logic [2:0] sel;
   logic       tick, hit;
   logic       unused_addr;

   assign wr   = req_i & we_i;
   assign rd   = req_i & ~we_i;
   assign sel  = addr_i[4:2];
   assign tick = en_q & (pcnt_q == presc_q);
   assign hit  = en_q & (mtime_q >= cmp_q);

   assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

   assign int_sig_o = pend_q & ie_q;

   always_comb begin
      en_d     = en_q;
      ie_d     = ie_q;
      pend_d   = pend_q;
      auto_d   = auto_q;
      presc_d  = presc_q;
      pcnt_d   = pcnt_q;
      mtime_d  = mtime_q;
      cmp_d    = cmp_q;
      shadow_d = shadow_q;

      // Prescaler restarts on any CTRL/PRESC write so a new rate or a fresh
      // enable always starts a full N+1 cycle period.
      if (wr && (sel == OFF_CTRL || sel == OFF_PRESC)) begin
         pcnt_d = '0;
      end else if (!en_q || tick) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
      end

      // A software write to either mtime half wins over increment and
      // auto-clear for the whole counter in that cycle.
      if (wr && sel == OFF_MT_LO) begin
         mtime_d = {mtime_q[63:32], data_i};
      end else if (wr && sel == OFF_MT_HI) begin
         mtime_d = {data_i, mtime_q[31:0]};
      end else if (hit && auto_q) begin
         mtime_d = '0;
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end

      if (wr && sel == OFF_CTRL) begin
         en_d   = data_i[0];
         ie_d   = data_i[1];
         auto_d = data_i[3];
         if (data_i[2]) begin
            pend_d = 1'b0;
         end
      end
      // Set has priority over the write-1-to-clear above.
      if (hit) begin
         pend_d = 1'b1;
      end

      if (wr && sel == OFF_PRESC) begin
         presc_d = data_i[PRESC_W-1:0];
      end
      if (wr && sel == OFF_CMP_LO) begin
         cmp_d[31:0] = data_i;
      end
      if (wr && sel == OFF_CMP_HI) begin
         cmp_d[63:32] = data_i;
      end

      // Low-word read snapshots the high word so a LO-then-HI pair is coherent.
      if (rd && sel == OFF_MT_LO) begin
         shadow_d = mtime_q[63:32];
      end
   end

   always_comb begin
      data_o = '0;
      if (rd) begin
         case (sel)
            OFF_CTRL:   data_o = {28'd0, auto_q, pend_q, ie_q, en_q};
            OFF_PRESC:  data_o = 32'(presc_q);
            OFF_MT_LO:  data_o = mtime_q[31:0];
            OFF_MT_HI:  data_o = shadow_q;
            OFF_CMP_LO: data_o = cmp_q[31:0];
            OFF_CMP_HI: data_o = cmp_q[63:32];
            default:    data_o = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         pend_q   <= 1'b0;
         auto_q   <= 1'b0;
         presc_q  <= '0;
         pcnt_q   <= '0;
         mtime_q  <= '0;
         cmp_q    <= '1;
         shadow_q <= '0;
      end else begin
         en_q     <= en_d;
         ie_q     <= ie_d;
         pend_q   <= pend_d;
         auto_q   <= auto_d;
         presc_q  <= presc_d;
         pcnt_q   <= pcnt_d;
         mtime_q  <= mtime_d;
         cmp_q    <= cmp_d;
         shadow_q <= shadow_d;
      end
   end

endmodule

// File: tb/tb_clint_mtimer.sv
// tb/tb_clint_mtimer.sv - self-checking bench for clint_mtimer
module tb_clint_mtimer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        int_sig_o;

   always #5 clk = ~clk;

   clint_mtimer #(.PRESC_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_i     (req_i),
      .we_i      (we_i),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .data_o    (data_o),
      .int_sig_o (int_sig_o)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state: the programmer-visible timer.
   logic        m_en, m_ie, m_pend, m_auto;
   logic [15:0] m_presc;
   logic [15:0] m_phase;
   logic [63:0] m_mtime;
   logic [63:0] m_cmp;
   logic [31:0] m_shadow;

   logic [31:0] g_rd;
   logic        g_int;

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_data;
      logic        exp_int;
   } vec_t;

   vec_t tbl[17];

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] off);
      case (off)
         3'd0:    return {28'd0, m_auto, m_pend, m_ie, m_en};
         3'd1:    return {16'd0, m_presc};
         3'd2:    return m_mtime[31:0];
         3'd3:    return m_shadow;
         3'd4:    return m_cmp[31:0];
         3'd5:    return m_cmp[63:32];
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_en = 0; m_ie = 0; m_pend = 0; m_auto = 0;
      m_presc = 0; m_phase = 0; m_mtime = 0;
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 0;
   endtask

   // One clock edge of the timer's architectural behaviour.
   task automatic m_step(input logic rstn, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
      logic [2:0]  off;
      logic        wrv, rdv, tick, hit;
      logic [63:0] nt;
      if (!rstn) begin
         m_reset();
         return;
      end
      off  = a[4:2];
      wrv  = r && w;
      rdv  = r && !w;
      tick = m_en && (m_phase == m_presc);
      hit  = m_en && (m_mtime >= m_cmp);

      if (wrv && off == 3'd2)      nt = {m_mtime[63:32], d};
      else if (wrv && off == 3'd3) nt = {d, m_mtime[31:0]};
      else if (hit && m_auto)      nt = 64'd0;
      else if (tick)               nt = m_mtime + 64'd1;
      else                         nt = m_mtime;

      if ((wrv && (off == 3'd0 || off == 3'd1)) || !m_en || tick) m_phase = 0;
      else m_phase = m_phase + 16'd1;

      if (rdv && off == 3'd2) m_shadow = m_mtime[63:32];

      if (hit) m_pend = 1;
      else if (wrv && off == 3'd0 && d[2]) m_pend = 0;

      if (wrv && off == 3'd0) begin
         m_en = d[0]; m_ie = d[1]; m_auto = d[3];
      end
      if (wrv && off == 3'd1) m_presc = d[15:0];
      if (wrv && off == 3'd4) m_cmp[31:0] = d;
      if (wrv && off == 3'd5) m_cmp[63:32] = d;
      m_mtime = nt;
   endtask

   task automatic cyc(input logic rstn, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
      logic [31:0] e;
      @(negedge clk);
      rst = rstn; req_i = r; we_i = w; addr_i = a; data_i = d;
      #1;
      g_rd  = data_o;
      g_int = int_sig_o;
      e = (r && !w) ? m_read(a[4:2]) : 32'd0;
      check32($sformatf("data_o model @%0t", $time), g_rd, e);
      check1($sformatf("int_sig_o model @%0t", $time), g_int, m_pend & m_ie);
      @(posedge clk);
      m_step(rstn, r, w, a, d);
   endtask

   task automatic idle();                                   cyc(1, 0, 0, 32'd0, 32'd0); endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d); cyc(1, 1, 1, a, d);       endtask
   task automatic rd(input logic [31:0] a);                 cyc(1, 1, 0, a, 32'd0);     endtask
   task automatic do_reset(input int n);
      repeat (n) cyc(0, 0, 0, 32'd0, 32'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          32'h0000_0000, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          32'h0000_0000, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,          32'h0000_0000, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hFFFF_FFFF, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,          32'hFFFF_FFFF, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 32'h0000_0018, 32'h0,          32'h0000_0000, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 32'h0000_001C, 32'h0,          32'h0000_0000, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 32'h0000_0018, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 32'h0000_0018, 32'h0,          32'h0000_0000, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          32'h0000_FFFF, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h0000_000B, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'h0000_0000, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 32'hABCD_0011, 32'h0,          32'hFFFF_FFFF, 1'b0};

      rst = 0; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
      @(posedge clk);
      m_step(0, 0, 0, 32'd0, 32'd0);

      // Reset values and register decode
      do_reset(3);
      for (int i = 0; i < 17; i++) begin
         cyc(1, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].data);
         check32($sformatf("tbl[%0d] data_o", i), g_rd, tbl[i].exp_data);
         check1($sformatf("tbl[%0d] int", i), g_int, tbl[i].exp_int);
      end

      // Prescaled count: PRESC=3, increments every 4 cycles
      do_reset(1);
      wr(32'h04, 32'd3);
      wr(32'h00, 32'h1);
      for (int k = 0; k <= 40; k++) begin
         rd(32'h08);
         check32($sformatf("presc mtime k=%0d", k), g_rd, 32'(k / 4));
      end

      // One-shot interrupt
      do_reset(1);
      wr(32'h14, 32'd0);
      wr(32'h10, 32'd5);
      wr(32'h00, 32'h3);
      for (int k = 0; k <= 6; k++) begin
         rd(32'h08);
         check32($sformatf("oneshot mtime k=%0d", k), g_rd, 32'(k));
         check1($sformatf("oneshot int k=%0d", k), g_int, k >= 6);
      end
      wr(32'h00, 32'h7);
      rd(32'h00);
      check32("oneshot pend resets", g_rd, 32'h7);
      wr(32'h10, 32'd100);
      wr(32'h00, 32'h7);
      for (int k = 11; k <= 101; k++) begin
         rd(32'h08);
         check32($sformatf("oneshot2 mtime k=%0d", k), g_rd, 32'(k));
         check1($sformatf("oneshot2 int k=%0d", k), g_int, k >= 101);
      end
      cyc(0, 0, 0, 32'd0, 32'd0);
      rd(32'h00);
      check32("ctrl after mid reset", g_rd, 32'h0);
      check1("int after mid reset", g_int, 1'b0);

      // Periodic mode
      do_reset(1);
      wr(32'h14, 32'd0);
      wr(32'h10, 32'd9);
      wr(32'h00, 32'hB);
      for (int k = 0; k < 30; k++) begin
         rd(32'h08);
         check32($sformatf("periodic mtime k=%0d", k), g_rd, 32'(k % 10));
         check1($sformatf("periodic int k=%0d", k), g_int, k >= 10);
      end
      repeat (5) idle();
      wr(32'h00, 32'hF);
      rd(32'h00);
      check32("periodic pend cleared", g_rd, 32'hB);
      idle();
      idle();
      wr(32'h00, 32'hF);
      rd(32'h00);
      check32("periodic set beats clear", g_rd, 32'hF);

      // Coherent read across the 32-bit carry
      do_reset(1);
      wr(32'h0C, 32'd0);
      wr(32'h08, 32'hFFFF_FFFE);
      wr(32'h00, 32'h1);
      rd(32'h08);
      check32("wrap lo k0", g_rd, 32'hFFFF_FFFE);
      rd(32'h08);
      check32("wrap lo k1", g_rd, 32'hFFFF_FFFF);
      idle();
      rd(32'h0C);
      check32("wrap shadow hi", g_rd, 32'd0);
      rd(32'h08);
      check32("wrap lo k4", g_rd, 32'd2);
      rd(32'h0C);
      check32("wrap hi k5", g_rd, 32'd1);

      // Write priority over tick, and CTRL disable in a tick cycle
      do_reset(1);
      wr(32'h04, 32'd1);
      wr(32'h00, 32'h1);
      idle(); idle(); idle();
      wr(32'h08, 32'h50);
      rd(32'h08);
      check32("wprio k4", g_rd, 32'h50);
      rd(32'h08);
      check32("wprio k5", g_rd, 32'h50);
      rd(32'h08);
      check32("wprio k6", g_rd, 32'h51);
      wr(32'h00, 32'h0);
      rd(32'h08);
      check32("disable tick k8", g_rd, 32'h52);
      idle();
      rd(32'h08);
      check32("disable held k10", g_rd, 32'h52);

      // Randomized traffic against the model
      do_reset(1);
      for (int n = 0; n < 3000; n++) begin
         int unsigned r;
         logic [2:0]  off;
         logic [31:0] a, d;
         r   = $urandom_range(0, 99);
         off = 3'($urandom_range(0, 7));
         a   = $urandom();
         a[4:2] = off;
         case (off)
            3'd0:    d = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
            3'd1:    d = 32'($urandom_range(0, 3));
            3'd2,
            3'd4:    d = 32'($urandom_range(0, 60));
            3'd3,
            3'd5:    d = ($urandom_range(0, 9) == 0) ? $urandom() : 32'd0;
            default: d = $urandom();
         endcase
         if (r < 2)       cyc(0, 0, 0, 32'd0, 32'd0);
         else if (r < 25) cyc(1, 1, 1, a, d);
         else if (r < 50) cyc(1, 1, 0, a, d);
         else             cyc(1, 0, $urandom_range(0, 1) != 0, a, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
